// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four 7-segment digit patterns onto one
// shared segment bus with one-hot digit anodes. A per-frame snapshot keeps a
// frame from mixing old and new digits, and a blanking interval at the start
// of each digit slot suppresses ghosting.
module seg7_scan_driver #(
  parameter int unsigned DIV            = 50000,
  parameter int unsigned BLANK          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [6:0] S7D1,
  input  logic [6:0] S7D2,
  input  logic [6:0] S7D3,
  input  logic [6:0] S7D4,
  output logic [6:0] Seg,
  output logic [3:0] Anode,
  output logic [1:0] Digit,
  output logic       FrameStart
);

  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [6:0]    SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0]    AN_OFF   = {4{AN_ACTIVE_LOW}};

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  logic [6:0]    r_snap [4];

  logic [6:0]    r_seg;
  logic [3:0]    r_anode;
  logic [1:0]    r_digit;
  logic          r_frame_start;

  logic          w_cnt_last;
  logic          w_lit;
  logic [3:0]    w_an_raw;
  logic [6:0]    w_seg_raw;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // With no blanking every cycle of the slot is lit; avoids a constant compare.
  generate
    if (BLANK == 0) begin : g_noblank
      assign w_lit = 1'b1;
    end else begin : g_blank
      assign w_lit = (r_cnt >= CW'(BLANK));
    end
  endgenerate

  // Active-high anode/segment values derived from the current scan state.
  always_comb begin
    w_an_raw  = '0;
    w_seg_raw = '0;
    if (Enable && w_lit) begin
      w_an_raw = 4'b0001 << r_dig;
    end
    if (w_an_raw != '0) begin
      w_seg_raw = r_snap[r_dig];
    end
  end

  // Prescaler, digit index and frame snapshot; all hold while disabled.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt <= '0;
      r_dig <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        r_snap[k] <= '0;
      end
    end else if (Enable) begin
      if (w_cnt_last) begin
        r_cnt <= '0;
        r_dig <= r_dig + 2'd1;
        if (r_dig == 2'd3) begin
          r_snap[0] <= S7D1;
          r_snap[1] <= S7D2;
          r_snap[2] <= S7D3;
          r_snap[3] <= S7D4;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Registered outputs with polarity applied at the flop.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_seg         <= SEG_OFF;
      r_anode       <= AN_OFF;
      r_digit       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_seg_raw ^ SEG_OFF;
      r_anode       <= w_an_raw ^ AN_OFF;
      r_digit       <= r_dig;
      r_frame_start <= Enable && (r_dig == 2'd0) && (r_cnt == '0);
    end
  end

  assign Seg        = r_seg;
  assign Anode      = r_anode;
  assign Digit      = r_digit;
  assign FrameStart = r_frame_start;

endmodule
